// File: rtl/crypto_pkg.sv
// Shared width, mode and FSM state definitions for the crypto stream driver.
package crypto_pkg;

  localparam int BLOCK_W = 128;

  localparam logic MODE_ENC = 1'b1;
  localparam logic MODE_DEC = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_OUTPUT    = 3'd4
  } state_t;

endpackage

// File: rtl/op_timer.sv
// Saturating cycle counter with synchronous clear, count enable and a
// comparison against a caller-supplied limit.
module op_timer #(
  parameter int W = 7
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_enable,
  input  logic [W-1:0] i_limit,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_expired = (r_count >= i_limit);

endmodule

// File: rtl/crypto_stream_driver.sv
// Stream-to-core initiator for the 128-bit block cipher core: one core operation
// per accepted block. Define CBC_CHAIN_EN to add CBC chaining; otherwise ECB.
module crypto_stream_driver
  import crypto_pkg::*;
#(
  parameter int BUSY_TIMEOUT = 8,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [BLOCK_W-1:0] s_data,
  input  logic               s_mode,
  input  logic [BLOCK_W-1:0] key,
  input  logic [BLOCK_W-1:0] iv,
  input  logic               iv_load,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [BLOCK_W-1:0] m_data,
  output logic               m_error,
  output logic               core_start,
  output logic               core_enc_dec,
  output logic [BLOCK_W-1:0] core_data_in,
  output logic [BLOCK_W-1:0] core_key_in,
  input  logic [BLOCK_W-1:0] core_data_out,
  input  logic               core_busy
);

  localparam int TIMER_W = $clog2(DONE_TIMEOUT + 1);

  state_t r_state;
  state_t w_state_next;

  logic               w_accept;
  logic               w_capture;
  logic               w_fail;
  logic               w_timer_clear;
  logic               w_timer_en;
  logic               w_timer_expired;
  logic [TIMER_W-1:0] w_timer_limit;

  logic [BLOCK_W-1:0] r_core_data_in;
  logic [BLOCK_W-1:0] r_core_key_in;
  logic               r_core_enc_dec;
  logic [BLOCK_W-1:0] r_m_data;
  logic               r_m_error;
  logic [BLOCK_W-1:0] w_block_to_core;
  logic [BLOCK_W-1:0] w_result;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_fail       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (s_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // A core that has started always wins over a same-cycle timeout.
        if (core_busy) begin
          w_state_next = ST_WAIT_DONE;
        end else if (w_timer_expired) begin
          w_fail       = 1'b1;
          w_state_next = ST_OUTPUT;
        end
      end
      ST_WAIT_DONE: begin
        if (!core_busy) begin
          w_capture    = 1'b1;
          w_state_next = ST_OUTPUT;
        end else if (w_timer_expired) begin
          w_fail       = 1'b1;
          w_state_next = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (m_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Timer restarts on every state change and only runs while waiting on the core.
  assign w_timer_clear = (w_state_next != r_state);
  assign w_timer_en    = (r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_DONE);
  assign w_timer_limit = (r_state == ST_WAIT_BUSY) ? TIMER_W'(BUSY_TIMEOUT)
                                                   : TIMER_W'(DONE_TIMEOUT);

  op_timer #(
    .W (TIMER_W)
  ) u_op_timer (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (w_timer_clear),
    .i_enable  (w_timer_en),
    .i_limit   (w_timer_limit),
    .o_expired (w_timer_expired)
  );

`ifdef CBC_CHAIN_EN
  logic [BLOCK_W-1:0] r_chain;
  logic [BLOCK_W-1:0] r_cipher_in;
  logic [BLOCK_W-1:0] w_chain_eff;

  // A same-cycle iv_load takes effect before the block is combined with the chain.
  assign w_chain_eff     = iv_load ? iv : r_chain;
  assign w_block_to_core = (s_mode == MODE_ENC) ? (s_data ^ w_chain_eff) : s_data;
  assign w_result        = (r_core_enc_dec == MODE_ENC) ? core_data_out
                                                        : (core_data_out ^ r_chain);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_chain     <= '0;
      r_cipher_in <= '0;
    end else begin
      if ((r_state == ST_IDLE) && iv_load) begin
        r_chain <= iv;
      end else if (w_capture) begin
        r_chain <= (r_core_enc_dec == MODE_ENC) ? core_data_out : r_cipher_in;
      end
      if (w_accept) begin
        r_cipher_in <= s_data;
      end
    end
  end
`else
  logic w_unused_cbc;

  assign w_block_to_core = s_data;
  assign w_result        = core_data_out;
  assign w_unused_cbc    = ^{iv, iv_load};
`endif

  // Core inputs change only on accept, so they stay stable through the capture cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_core_data_in <= '0;
      r_core_key_in  <= '0;
      r_core_enc_dec <= 1'b0;
      r_m_data       <= '0;
      r_m_error      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_core_data_in <= w_block_to_core;
        r_core_key_in  <= key;
        r_core_enc_dec <= s_mode;
      end
      if (w_capture) begin
        r_m_data  <= w_result;
        r_m_error <= 1'b0;
      end else if (w_fail) begin
        r_m_data  <= '0;
        r_m_error <= 1'b1;
      end
    end
  end

  assign s_ready      = (r_state == ST_IDLE) && !reset;
  assign m_valid      = (r_state == ST_OUTPUT);
  assign m_data       = r_m_data;
  assign m_error      = r_m_error;
  assign core_start   = (r_state == ST_ISSUE);
  assign core_enc_dec = r_core_enc_dec;
  assign core_data_in = r_core_data_in;
  assign core_key_in  = r_core_key_in;

endmodule

// File: tb/tb_crypto_stream_driver.sv
// Directed bench for crypto_stream_driver with a behavioural AES-128 core
// (busy high for 10 cycles). The CBC test runs when CBC_CHAIN_EN is defined.
module tb_crypto_stream_driver;
  import crypto_pkg::*;

  localparam int LC = 10;
  localparam int BT = 8;
  localparam int DT = 64;

  logic         clock = 1'b0;
  logic         reset;
  logic         s_valid, s_ready, s_mode, iv_load;
  logic [127:0] s_data, key, iv;
  logic         m_valid, m_ready, m_error;
  logic [127:0] m_data;
  logic         core_start, core_enc_dec, core_busy;
  logic [127:0] core_data_in, core_key_in, core_data_out;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  crypto_stream_driver #(
    .BUSY_TIMEOUT (BT),
    .DONE_TIMEOUT (DT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_mode        (s_mode),
    .key           (key),
    .iv            (iv),
    .iv_load       (iv_load),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_error       (m_error),
    .core_start    (core_start),
    .core_enc_dec  (core_enc_dec),
    .core_data_in  (core_data_in),
    .core_key_in   (core_key_in),
    .core_data_out (core_data_out),
    .core_busy     (core_busy)
  );

  // AES-128 reference
  logic [7:0] sbox  [256];
  logic [7:0] isbox [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox_entry(input logic [7:0] a);
    logic [7:0] p;
    p = 8'h01;
    for (int k = 0; k < 254; k++) p = gmul(p, a);
    return p ^ rotl8(p, 1) ^ rotl8(p, 2) ^ rotl8(p, 3) ^ rotl8(p, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) y[8*i +: 8] = inv ? isbox[x[8*i +: 8]] : sbox[x[8*i +: 8]];
    return y;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    y = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!inv) y[127-8*(r+4*c) -: 8] = x[127-8*(r+4*((c+r)%4)) -: 8];
        else      y[127-8*(r+4*((c+r)%4)) -: 8] = x[127-8*(r+4*c) -: 8];
    return y;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] x, input bit inv);
    logic [7:0]   m [4];
    logic [7:0]   a [4];
    logic [7:0]   acc;
    logic [127:0] y;
    if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
    y = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = x[127-8*(r+4*c) -: 8];
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(a[j], m[(j-i+4)%4]);
        y[127-8*(i+4*c) -: 8] = acc;
      end
    end
    return y;
  endfunction

  function automatic logic [127:0] aes(input logic [127:0] blk, input logic [127:0] k, input bit inv);
    logic [31:0]  w  [44];
    logic [127:0] rk [11];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] s;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    if (!inv) begin
      s = blk ^ rk[0];
      for (int r = 1; r < 11; r++) begin
        s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
        if (r < 10) s = mix_cols(s, 1'b0);
        s = s ^ rk[r];
      end
    end else begin
      s = blk ^ rk[10];
      for (int r = 9; r >= 0; r--) begin
        s = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk[r];
        if (r > 0) s = mix_cols(s, 1'b1);
      end
    end
    return s;
  endfunction

  // Core model: 0 = normal, 1 = never goes busy, 2 = stays busy
  int           core_mode = 0;
  logic         core_kill = 1'b0;
  int           busy_cnt  = 0;
  logic [127:0] res_e = '0, res_d = '0;

  initial core_busy = 1'b0;
  assign core_data_out = core_enc_dec ? res_e : res_d;

  always @(posedge clock) begin
    if (core_kill) begin
      core_busy <= 1'b0;
    end else if (core_start && core_mode != 1) begin
      res_e     <= aes(core_data_in, core_key_in, 1'b0);
      res_d     <= aes(core_data_in, core_key_in, 1'b1);
      core_busy <= 1'b1;
      busy_cnt  <= LC;
    end else if (core_busy && core_mode == 0) begin
      if (busy_cnt == 1) core_busy <= 1'b0;
      busy_cnt <= busy_cnt - 1;
    end
  end

  // Interface monitor
  int           start_hi = 0, start_pulses = 0, start_maxw = 0, gap = 0, min_gap = 1000;
  int           xfers = 0, hold_err = 0;
  logic [127:0] held_in = '0, held_key = '0;
  logic         held_mode = 1'b0;

  always @(posedge clock) begin
    if (core_start) begin
      if (start_hi == 0) begin
        start_pulses <= start_pulses + 1;
        if (start_pulses > 0 && gap < min_gap) min_gap <= gap;
        held_in   <= core_data_in;
        held_key  <= core_key_in;
        held_mode <= core_enc_dec;
      end
      start_hi <= start_hi + 1;
      if (start_hi + 1 > start_maxw) start_maxw <= start_hi + 1;
      gap <= 0;
    end else begin
      start_hi <= 0;
      gap      <= gap + 1;
    end
    if (core_busy && (core_data_in !== held_in || core_key_in !== held_key || core_enc_dec !== held_mode))
      hold_err <= hold_err + 1;
    if (m_valid && m_ready) xfers <= xfers + 1;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_s_ready"},      128'(s_ready),      '0);
    chk({p, "_m_valid"},      128'(m_valid),      '0);
    chk({p, "_m_error"},      128'(m_error),      '0);
    chk({p, "_core_start"},   128'(core_start),   '0);
    chk({p, "_core_enc_dec"}, 128'(core_enc_dec), '0);
    chk({p, "_m_data"},       m_data,             '0);
    chk({p, "_core_data_in"}, core_data_in,       '0);
    chk({p, "_core_key_in"},  core_key_in,        '0);
  endtask

  task automatic send(input logic [127:0] d, input logic md, input logic [127:0] k,
                      input logic ld, input logic [127:0] ivv);
    int n;
    n = 0;
    while (s_ready !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("send_ready", 128'(s_ready), 128'(1));
    s_data = d; s_mode = md; key = k; iv_load = ld; iv = ivv; s_valid = 1'b1;
    @(negedge clock);
    s_valid = 1'b0; iv_load = 1'b0;
  endtask

  task automatic recv(output logic [127:0] d, output logic e, output int lat,
                      output int sr, input bit keep);
    lat = 0; sr = 0; m_ready = 1'b1;
    while (m_valid !== 1'b1 && lat < 300) begin
      if (s_ready) sr++;
      @(negedge clock);
      lat++;
    end
    chk("recv_valid", 128'(m_valid), 128'(1));
    d = m_data; e = m_error;
    @(negedge clock);
    if (!keep) m_ready = 1'b0;
  endtask

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    logic [127:0] d, d0;
    logic [127:0] v_in  [3];
    logic [127:0] v_key [3];
    logic [127:0] v_exp [3];
    logic         v_md  [3];
    logic         e;
    int           lat, sr, x0, bad, p0;

    for (int a = 0; a < 256; a++) begin
      sbox[a] = sbox_entry(8'(a));
      isbox[sbox[a]] = 8'(a);
    end

    reset = 1'b1; s_valid = 1'b0; s_mode = 1'b0; s_data = '0; key = '0;
    iv = '0; iv_load = 1'b0; m_ready = 1'b0;
    @(negedge clock);
    chk_zero("rst");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_s_ready", 128'(s_ready), 128'(1));

    // 1: ECB encrypt FIPS-197 vector
    p0 = start_pulses;
    send(P1, MODE_ENC, K1, 1'b1, '0);
    recv(d, e, lat, sr, 1'b0);
    $display("t1 enc: m_data=%h m_error=%0b lat=%0d", d, e, lat);
    chk("t1_data", d, C1);
    chk("t1_err", 128'(e), '0);
    chk("t1_start_width", 128'(start_maxw), 128'(1));
    chk("t1_start_pulses", 128'(start_pulses - p0), 128'(1));
    chk("t1_mvalid_after", 128'(m_valid), '0);

    // 2: ECB decrypt back to plaintext
    send(C1, MODE_DEC, K1, 1'b1, '0);
    recv(d, e, lat, sr, 1'b0);
    $display("t2 dec: m_data=%h m_error=%0b", d, e);
    chk("t2_data", d, P1);
    chk("t2_err", 128'(e), '0);

    // 3: three blocks back to back with m_ready held high
    v_in  = '{P1, C1, '0};
    v_key = '{K1, K1, '0};
    v_md  = '{MODE_ENC, MODE_DEC, MODE_ENC};
    v_exp = '{C1, P1, CZ};
    for (int i = 0; i < 3; i++) begin
      send(v_in[i], v_md[i], v_key[i], 1'b1, '0);
      recv(d, e, lat, sr, 1'b1);
      $display("t3 blk%0d: m_data=%h s_ready_hi=%0d", i, d, sr);
      chk($sformatf("t3_data%0d", i), d, v_exp[i]);
      chk($sformatf("t3_sready%0d", i), 128'(sr), '0);
    end
    m_ready = 1'b0;
    chk("t3_start_gap_ge2", 128'(min_gap >= 2), 128'(1));
    chk("t3_start_width", 128'(start_maxw), 128'(1));

    // 4: backpressure for 20 cycles
    send('0, MODE_ENC, '0, 1'b1, '0);
    lat = 0;
    while (m_valid !== 1'b1 && lat < 300) begin
      @(negedge clock);
      lat++;
    end
    chk("t4_valid", 128'(m_valid), 128'(1));
    d0 = m_data; bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (m_valid !== 1'b1 || m_data !== d0 || m_error !== 1'b0 || s_ready !== 1'b0) bad++;
    end
    $display("t4 bp: m_data=%h unstable=%0d", d0, bad);
    chk("t4_data", d0, CZ);
    chk("t4_held", 128'(bad), '0);
    x0 = xfers;
    m_ready = 1'b1;
    @(negedge clock);
    m_ready = 1'b0;
    chk("t4_one_xfer", 128'(xfers - x0), 128'(1));
    chk("t4_mvalid_low", 128'(m_valid), '0);
    chk("core_hold", 128'(hold_err), '0);

    // 5a: busy never rises -> busy timeout error
    core_mode = 1;
    send(P1, MODE_ENC, K1, 1'b1, '0);
    recv(d, e, lat, sr, 1'b0);
    $display("t5 busy timeout: m_data=%h m_error=%0b lat=%0d", d, e, lat);
    chk("t5_bt_err", 128'(e), 128'(1));
    chk("t5_bt_data", d, '0);
    chk("t5_bt_lat", 128'(lat >= BT + 1 && lat <= BT + 3), 128'(1));

    // 5b: busy never falls -> done timeout error
    core_mode = 2;
    send(P1, MODE_ENC, K1, 1'b1, '0);
    recv(d, e, lat, sr, 1'b0);
    $display("t5 done timeout: m_data=%h m_error=%0b lat=%0d", d, e, lat);
    chk("t5_dt_err", 128'(e), 128'(1));
    chk("t5_dt_data", d, '0);
    chk("t5_dt_lat_min", 128'(lat >= DT), 128'(1));
    core_kill = 1'b1;
    @(negedge clock);
    core_kill = 1'b0;

    // 5c: reset while waiting for the core to finish
    send(P1, MODE_ENC, K1, 1'b1, '0);
    repeat (5) @(negedge clock);
    chk("t5_pre_reset_mvalid", 128'(m_valid), '0);
    reset = 1'b1;
    #1;
    chk_zero("t5_rst");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    core_mode = 0;
    core_kill = 1'b1;
    @(negedge clock);
    core_kill = 1'b0;
    m_ready = 1'b1; x0 = xfers; bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (m_valid !== 1'b0) bad++;
    end
    m_ready = 1'b0;
    $display("t5 reset abort: m_valid_seen=%0d xfers=%0d", bad, xfers - x0);
    chk("t5_no_result", 128'(bad), '0);
    chk("t5_no_xfer", 128'(xfers - x0), '0);
    chk("t5_idle_ready", 128'(s_ready), 128'(1));

    send(P1, MODE_ENC, K1, 1'b1, '0);
    recv(d, e, lat, sr, 1'b0);
    $display("t5 recovery: m_data=%h m_error=%0b", d, e);
    chk("t5_recover_data", d, C1);
    chk("t5_recover_err", 128'(e), '0);

`ifdef CBC_CHAIN_EN
    // 6: CBC round trip using SP 800-38A CBC-AES128 vectors
    begin
      logic [127:0] k2, ivc, pa, pb, ca, cb;
      k2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      ivc = 128'h000102030405060708090a0b0c0d0e0f;
      pa  = 128'h6bc1bee22e409f96e93d7e117393172a;
      pb  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
      ca  = 128'h7649abac8119b246cee98e9b12e9197d;
      cb  = 128'h5086cb9b507219ee95db113a917678b2;
      send(pa, MODE_ENC, k2, 1'b1, ivc);
      recv(d, e, lat, sr, 1'b0);
      $display("t6 cbc enc0: m_data=%h", d);
      chk("t6_enc0", d, ca);
      send(pb, MODE_ENC, k2, 1'b0, '0);
      recv(d, e, lat, sr, 1'b0);
      $display("t6 cbc enc1: m_data=%h", d);
      chk("t6_enc1", d, cb);
      iv = ivc; iv_load = 1'b1;
      @(negedge clock);
      iv_load = 1'b0;
      send(ca, MODE_DEC, k2, 1'b0, '0);
      recv(d, e, lat, sr, 1'b0);
      $display("t6 cbc dec0: m_data=%h", d);
      chk("t6_dec0", d, pa);
      send(cb, MODE_DEC, k2, 1'b0, '0);
      recv(d, e, lat, sr, 1'b0);
      $display("t6 cbc dec1: m_data=%h", d);
      chk("t6_dec1", d, pb);
    end
`else
    // 6 (ECB build): iv and iv_load have no effect on the result
    send(P1, MODE_ENC, K1, 1'b1, {128{1'b1}});
    recv(d, e, lat, sr, 1'b0);
    $display("t6 ecb iv ignored: m_data=%h", d);
    chk("t6_ecb_iv_ignored", d, C1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
